hook_sequencer: RTL and testbench

HOOK_SEQUENCER -- requirements
Module: hook_sequencer

---
 rtl/hook_sequencer.sv | 137 +++++++++++++
 tb/tb_hook_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hook_sequencer.sv
// Hook launch/retract sequencer: swings at rest length, extends on fire, retracts with or
// without a grabbed object, and pulses delivered once a grabbed object reaches rest length.
module hook_sequencer #(
  parameter int unsigned MIN_LENGTH  = 20,
  parameter int unsigned MAX_LENGTH  = 400,
  parameter int unsigned EXTEND_STEP = 4
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        fire,
  input  logic        collision,
  input  logic [1:0]  objWeight,
  input  logic        edgeHit,
  output logic        swingEnable,
  output logic [10:0] length,
  output logic        grabbed,
  output logic        delivered,
  output logic [1:0]  deliveredWeight,
  output logic        busy
);

  localparam logic [11:0] MinLen = 12'(MIN_LENGTH);
  localparam logic [11:0] MaxLen = 12'(MAX_LENGTH);
  localparam logic [11:0] ExtStep = 12'(EXTEND_STEP);

  typedef enum logic [1:0] {StSwing, StExtend, StRetract, StDeliver} state_e;

  state_e      state_q, state_d;
  logic [10:0] length_q, length_d;
  logic        grabbed_q, grabbed_d;
  logic        delivered_q, delivered_d;
  logic [1:0]  dweight_q, dweight_d;
  logic [1:0]  weight_q, weight_d;
  logic        launch_q, launch_d;
  logic        hit_q, hit_d;
  logic        fire_q;

  logic        fire_rise;
  logic [11:0] ext_sum;
  logic [11:0] ret_step;
  logic [11:0] ret_next;

  assign fire_rise = fire & ~fire_q;
  assign ext_sum   = {1'b0, length_q} + ExtStep;
  // Heavier objects retract slower: weight 0..3 gives 4..1 pixels per frame.
  assign ret_step  = grabbed_q ? 12'(3'd4 - {1'b0, weight_q}) : 12'd6;
  assign ret_next  = ({1'b0, length_q} >= MinLen + ret_step) ? ({1'b0, length_q} - ret_step)
                                                              : MinLen;

  always_comb begin
    state_d     = state_q;
    length_d    = length_q;
    grabbed_d   = grabbed_q;
    delivered_d = 1'b0;
    dweight_d   = dweight_q;
    weight_d    = weight_q;
    launch_d    = 1'b0;
    hit_d       = hit_q;

    case (state_q)
      StSwing: begin
        length_d = MinLen[10:0];
        launch_d = launch_q | fire_rise;
        if (startOfFrame && launch_q) begin
          state_d  = StExtend;
          launch_d = 1'b0;
        end
      end
      StExtend: begin
        if (collision) begin
          hit_d = 1'b1;
          if (!hit_q) weight_d = objWeight;
        end
        if (startOfFrame) begin
          if (hit_q) begin
            state_d   = StRetract;
            grabbed_d = 1'b1;
            hit_d     = 1'b0;
          end else if (edgeHit || ({1'b0, length_q} == MaxLen)) begin
            state_d = StRetract;
            hit_d   = 1'b0;
          end else begin
            length_d = (ext_sum >= MaxLen) ? MaxLen[10:0] : ext_sum[10:0];
          end
        end
      end
      StRetract: begin
        if (startOfFrame) begin
          length_d = ret_next[10:0];
          if (ret_next == MinLen) state_d = grabbed_q ? StDeliver : StSwing;
        end
      end
      StDeliver: begin
        if (startOfFrame) begin
          delivered_d = 1'b1;
          dweight_d   = weight_q;
          grabbed_d   = 1'b0;
          state_d     = StSwing;
        end
      end
      default: state_d = StSwing;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= StSwing;
      length_q    <= MinLen[10:0];
      grabbed_q   <= 1'b0;
      delivered_q <= 1'b0;
      dweight_q   <= 2'd0;
      weight_q    <= 2'd0;
      launch_q    <= 1'b0;
      hit_q       <= 1'b0;
      fire_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      length_q    <= length_d;
      grabbed_q   <= grabbed_d;
      delivered_q <= delivered_d;
      dweight_q   <= dweight_d;
      weight_q    <= weight_d;
      launch_q    <= launch_d;
      hit_q       <= hit_d;
      fire_q      <= fire;
    end
  end

  assign swingEnable     = (state_q == StSwing);
  assign busy            = ~swingEnable;
  assign length          = length_q;
  assign grabbed         = grabbed_q;
  assign delivered       = delivered_q;
  assign deliveredWeight = dweight_q;

endmodule

// File: tb/tb_hook_sequencer.sv
// Scoreboard bench for hook_sequencer: the driver queues the expected per-frame state, a
// monitor compares it after every startOfFrame edge and checks each delivered pulse.
module tb_hook_sequencer;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        sof = 1'b0;
  logic        fire = 1'b0;
  logic        collision = 1'b0;
  logic [1:0]  objWeight = 2'd0;
  logic        edgeHit = 1'b0;
  logic        swingEnable;
  logic [10:0] length;
  logic        grabbed;
  logic        delivered;
  logic [1:0]  deliveredWeight;
  logic        busy;

  hook_sequencer dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (sof),
    .fire           (fire),
    .collision      (collision),
    .objWeight      (objWeight),
    .edgeHit        (edgeHit),
    .swingEnable    (swingEnable),
    .length         (length),
    .grabbed        (grabbed),
    .delivered      (delivered),
    .deliveredWeight(deliveredWeight),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          frame_no = 0;
  int          dlv_cycles = 0;
  logic        sof_d = 1'b0;
  logic [1:0]  cur_dw = 2'd0;
  // {swingEnable, busy, grabbed, delivered, deliveredWeight, length}
  logic [16:0] exp_q[$];
  logic [1:0]  dlv_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  always @(posedge clk) sof_d <= sof;

  always @(negedge clk) begin
    if (sof_d) begin
      frame_no++;
      if (exp_q.size() == 0) fail($sformatf("frame %0d", frame_no));
      else check($sformatf("frame %0d", frame_no),
                 {15'd0, swingEnable, busy, grabbed, delivered, deliveredWeight, length},
                 {15'd0, exp_q.pop_front()});
    end
    if (delivered) begin
      dlv_cycles++;
      if (dlv_q.size() == 0) fail("delivered pulse");
      else check("delivered weight", {30'd0, deliveredWeight}, {30'd0, dlv_q.pop_front()});
    end
  end

  task automatic frame(input logic se, input logic gr, input int len, input logic dl = 1'b0);
    exp_q.push_back({se, ~se, gr, dl, cur_dw, 11'(len)});
    @(negedge clk) sof = 1'b1;
    @(negedge clk) sof = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_fire();
    @(negedge clk) fire = 1'b1;
    @(negedge clk) fire = 1'b0;
  endtask

  task automatic deliver(input logic [1:0] w);
    cur_dw = w;
    dlv_q.push_back(w);
    frame(1'b1, 1'b0, 20, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset length", {21'd0, length}, 32'd20);
    check("reset swingEnable/busy", {30'd0, swingEnable, busy}, 32'b10);
    check("reset grabbed/delivered", {30'd0, grabbed, delivered}, 32'b00);
    resetN = 1'b1;

    // Idle swing with fire low.
    repeat (10) frame(1'b1, 1'b0, 20);

    // Full-length extension, one frame at max, unloaded retract by 6 with floor.
    pulse_fire();
    frame(1'b0, 1'b0, 20);
    for (int i = 1; i <= 95; i++) frame(1'b0, 1'b0, 20 + 4 * i);
    frame(1'b0, 1'b0, 400);
    for (int k = 1; k <= 64; k++) begin
      int v;
      v = 400 - 6 * k;
      if (v < 20) v = 20;
      frame(v == 20, 1'b0, v);
    end
    frame(1'b1, 1'b0, 20);
    check("no delivery after empty retract", dlv_cycles, 0);

    // Collision and edge in the same frame at 100: the grab wins, weight 0 retracts by 4.
    pulse_fire();
    frame(1'b0, 1'b0, 20);
    for (int i = 1; i <= 20; i++) frame(1'b0, 1'b0, 20 + 4 * i);
    @(negedge clk);
    collision = 1'b1;
    edgeHit   = 1'b1;
    objWeight = 2'd0;
    frame(1'b0, 1'b1, 100);
    collision = 1'b0;
    edgeHit   = 1'b0;
    for (int k = 1; k <= 20; k++) frame(1'b0, 1'b1, 100 - 4 * k);
    deliver(2'd0);

    // Weight-3 grab at 60; weight changes after the first collision cycle must be ignored.
    pulse_fire();
    frame(1'b0, 1'b0, 20);
    for (int i = 1; i <= 10; i++) frame(1'b0, 1'b0, 20 + 4 * i);
    @(negedge clk);
    collision = 1'b1;
    objWeight = 2'd3;
    @(negedge clk) objWeight = 2'd1;
    frame(1'b0, 1'b1, 60);
    collision = 1'b0;
    for (int k = 1; k <= 40; k++) frame(1'b0, 1'b1, 60 - k);
    deliver(2'd3);
    frame(1'b1, 1'b0, 20);

    // Fire held high: one launch only, relaunch needs a fresh rising edge.
    @(negedge clk) fire = 1'b1;
    frame(1'b0, 1'b0, 20);
    frame(1'b0, 1'b0, 24);
    @(negedge clk) edgeHit = 1'b1;
    frame(1'b0, 1'b0, 24);
    edgeHit = 1'b0;
    frame(1'b1, 1'b0, 20);
    repeat (3) frame(1'b1, 1'b0, 20);
    @(negedge clk) fire = 1'b0;
    pulse_fire();
    frame(1'b0, 1'b0, 20);

    // Reset mid-retract with an object attached.
    frame(1'b0, 1'b0, 24);
    frame(1'b0, 1'b0, 28);
    @(negedge clk);
    collision = 1'b1;
    objWeight = 2'd2;
    frame(1'b0, 1'b1, 28);
    collision = 1'b0;
    frame(1'b0, 1'b1, 26);
    @(negedge clk) resetN = 1'b0;
    #1;
    check("abort length", {21'd0, length}, 32'd20);
    check("abort grabbed/delivered", {30'd0, grabbed, delivered}, 32'b00);
    check("abort swingEnable", {31'd0, swingEnable}, 32'd1);
    check("abort deliveredWeight", {30'd0, deliveredWeight}, 32'd0);
    @(negedge clk) resetN = 1'b1;
    cur_dw = 2'd0;
    repeat (3) frame(1'b1, 1'b0, 20);

    repeat (4) @(negedge clk);
    check("delivered pulse cycles", dlv_cycles, 2);
    check("frame queue drained", exp_q.size(), 0);
    check("delivery queue drained", dlv_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
